fetch_prefetch_buffer: RTL and testbench

Parametrised fetch front-end that replaces the single-PC fetch stage: PC generator, synchronous instruction-memory request port, DEPTH-entry prefetch queue of {pc, instr} pairs.
Decouples fetch from decode with a valid/ready handshake.
Supports branch/jump redirect with flush and discard of in-flight fetches.
Sits between instruction memory and the F/D pipeline register.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_prefetch_buffer_if.sv | 40 ++++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_prefetch_buffer.sv | 93 +++++++++
 tb/tb_fetch_prefetch_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front-end.
//   RESET_PC_DEFAULT : first fetch address after reset
//   INSTR_BYTES      : PC increment per fetched instruction
//   NOP_INSTR        : MIPS NOP encoding, also the cleared-storage value
//   fetch_entry_t    : one prefetch queue entry {pc, instr}
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Bus bundle of the fetch front-end: instruction-memory request/response,
// redirect input from branch resolution and the decode-side output handshake.
//
// Handshake: the head entry transfers to decode in a cycle where
// out_valid && out_ready are both 1 at the rising edge. out_valid does not
// depend on out_ready. Instruction memory has no ready: a request with
// imem_req_valid=1 in cycle t is always answered on imem_rsp_data in cycle t+1.
//
// Modports:
//   master : the fetch unit (drives requests and the decode-side outputs)
//   slave  : the environment (memory, branch unit, decode)
interface fetch_prefetch_buffer_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;
  logic [CNT_W-1:0]   count;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, count,
    input  imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, count,
    output imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding prefetched {pc, instr} entries.
//   clk, reset : clock and asynchronous active-high reset
//   push/push_data : write an entry at the tail
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : empty the queue; overrides push and pop in the same cycle
//   head       : current head entry (stale storage when empty)
//   count      : number of occupied entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch front-end: PC generator, single-cycle instruction-memory request
// port and a DEPTH-entry prefetch queue feeding decode.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_prefetch_buffer_if.master (imem request/response,
//           redirect, decode-side valid/ready output, occupancy count)
// A request is issued only when the queue plus the one possible in-flight
// response still fits, so the queue can never overflow. A redirect flushes
// the queue, drops any in-flight response and restarts fetch at redirect_pc.
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 32,
  parameter int          INSTR_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_prefetch_buffer_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic              issue;
  logic              push;
  logic              pop;
  logic              valid_head;
  logic [CNT_W:0]    used;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            push_data;
  entry_t            head;

  // Credit: occupied entries plus the response still on its way. A pop in
  // the same cycle is deliberately not credited back.
  assign used  = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
  assign issue = !bus.redirect_valid && (used < (CNT_W+1)'(DEPTH));

  assign valid_head = (fifo_count != '0) && !bus.redirect_valid;
  assign pop        = valid_head && bus.out_ready;
  assign push       = inflight && !bus.redirect_valid;

  assign push_data.pc    = inflight_pc;
  assign push_data.instr = bus.imem_rsp_data;

  assign bus.imem_req_valid = !reset && issue;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = !reset && valid_head;
  assign bus.out_pc         = head.pc;
  assign bus.out_instr      = head.instr;
  assign bus.count          = fifo_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic clk;
  logic reset;

  int total;
  int bad;

  // reference model: queue of {pc, instr}, at most one pending fetch
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  int          m_pend;
  logic [31:0] m_pend_pc;

  logic [31:0] last_req_addr;
  logic        last_req_valid;
  logic        last_out_valid;

  fetch_prefetch_buffer_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) bus_if ();

  fetch_prefetch_buffer #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .INSTR_W  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: answers exactly one cycle after a request,
  // garbage otherwise
  always @(posedge clk) begin
    if (bus_if.imem_req_valid) bus_if.imem_rsp_data <= bus_if.imem_req_addr ^ K;
    else                       bus_if.imem_rsp_data <= $urandom();
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = RPC;
    m_pend = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic e_req;
    logic e_ov;
    logic [63:0] h;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = rpc;
    bus_if.out_ready      = rdy;
    #2;
    e_req = !rv && ((mq.size() + m_pend) < DEPTH);
    e_ov  = (mq.size() != 0) && !rv;
    last_req_valid = bus_if.imem_req_valid;
    last_req_addr  = bus_if.imem_req_addr;
    last_out_valid = bus_if.out_valid;
    chk("req_valid", {63'd0, bus_if.imem_req_valid}, {63'd0, e_req});
    if (e_req) chk("req_addr", {32'd0, bus_if.imem_req_addr}, {32'd0, m_pc});
    chk("out_valid", {63'd0, bus_if.out_valid}, {63'd0, e_ov});
    chk("count", {61'd0, bus_if.count}, 64'(mq.size()));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("out_pc", {32'd0, bus_if.out_pc}, {32'd0, h[63:32]});
      chk("out_instr", {32'd0, bus_if.out_instr}, {32'd0, h[31:0]});
    end
    // model update at the coming edge
    if (rv) begin
      mq.delete();
      m_pend = 0;
      m_pc   = rpc;
    end else begin
      if (e_ov && rdy) void'(mq.pop_front());
      if (m_pend != 0) mq.push_back({m_pend_pc, m_pend_pc ^ K});
      m_pend = e_req ? 1 : 0;
      if (e_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.out_ready      = 1'b0;
    bus_if.imem_rsp_data  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // reset state
    chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("rst_req_valid", {63'd0, bus_if.imem_req_valid}, 64'd0);
    chk("rst_count", {61'd0, bus_if.count}, 64'd0);
    chk("rst_out_pc", {32'd0, bus_if.out_pc}, 64'd0);
    chk("rst_out_instr", {32'd0, bus_if.out_instr}, 64'd0);
    reset = 1'b0;

    // streaming with decode always ready
    cycle(1'b0, 32'd0, 1'b1);
    chk("first_req", {32'd0, last_req_addr}, 64'h3000);
    cycle(1'b0, 32'd0, 1'b1);
    chk("no_valid_c1", {63'd0, last_out_valid}, 64'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("valid_c2", {63'd0, last_out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b1);

    // back-pressure: queue fills to DEPTH and requests stop
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b0);
    chk("full_count", {61'd0, bus_if.count}, 64'(DEPTH));
    chk("full_no_req", {63'd0, last_req_valid}, 64'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

    // redirect with count=3 and one response in flight
    for (int i = 0; i < 10 && !(mq.size() == 3 && m_pend == 1); i++) cycle(1'b0, 32'd0, 1'b0);
    chk("pre_redir_count", {61'd0, bus_if.count}, 64'd3);
    cycle(1'b1, 32'h0000_4000, 1'b0);
    chk("redir_masks_valid", {63'd0, last_out_valid}, 64'd0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("redir_req_addr", {32'd0, last_req_addr}, 64'h4000);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);

    // redirect together with out_ready, count=2
    for (int i = 0; i < 10 && mq.size() != 2; i++) cycle(1'b0, 32'd0, 1'b0);
    chk("pre_redir2_count", {61'd0, bus_if.count}, 64'd2);
    cycle(1'b1, 32'h0000_5000, 1'b1);
    chk("redir2_no_pop", {63'd0, last_out_valid}, 64'd0);
    chk("redir2_flushed", {61'd0, bus_if.count}, 64'd0);

    // back-to-back redirects, then address wrap
    cycle(1'b1, 32'h0000_6000, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap0", {32'd0, last_req_addr}, 64'hFFFF_FFF8);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap1", {32'd0, last_req_addr}, 64'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1);
    chk("wrap2", {32'd0, last_req_addr}, 64'h0000_0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      cycle(rv, rpc, ($urandom_range(0, 3) != 0));
    end

    // async reset between edges with a non-empty queue
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0);
    bus_if.redirect_valid = 1'b0;
    bus_if.out_ready      = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("arst_req_valid", {63'd0, bus_if.imem_req_valid}, 64'd0);
    chk("arst_count", {61'd0, bus_if.count}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 32'd0, 1'b1);
    chk("post_rst_req", {32'd0, last_req_addr}, 64'h3000);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
